// File: rtl/regfile_pkg.sv
// Shared constants and address-width helper for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  function automatic int addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bus of regfile_mp; decode and writeback drive master, the file is slave.
interface regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 1
);
  import regfile_pkg::*;

  localparam int AW = addr_width(NREG);

  logic [NRP-1:0]      rd_en;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_pend;
  logic [NWP-1:0]      wr_en;
  logic [NWP*AW-1:0]   wr_addr;
  logic [NWP*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_pend
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_pend
  );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: flush > reserve > write-clear; x0 never pending.
// Lookups are combinational on pre-edge state; the parent registers them.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 1,
  parameter int AW   = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  input  logic [NRP*AW-1:0] lk_addr,
  output logic [NRP-1:0]    lk_pend
);

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Reservation is applied after the write clears so the younger reserve wins.
  always_comb begin
    pend_nxt = pend;
    for (int j = 0; j < NWP; j++) begin
      if (wr_en[j]) begin
        pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) begin
      pend_nxt[rsv_addr] = 1'b1;
    end
    pend_nxt[ZERO_REG] = 1'b0;
    if (flush) begin
      pend_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_comb begin
    lk_pend = '0;
    for (int i = 0; i < NRP; i++) begin
      lk_pend[i] = pend[lk_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRP-read/NWP-write register file with hardwired x0 and pending scoreboard.
// 1-cycle registered reads, no backpressure; REGFILE_BYPASS_EN adds same-edge write forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int NWP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);

  localparam int AW = addr_width(NREG);

  logic [XLEN-1:0] regs   [NREG];
  logic [AW-1:0]   ra     [NRP];
  logic [XLEN-1:0] rd_val [NRP];
  logic [XLEN-1:0] rd_q   [NRP];
  logic [NRP-1:0]  pend_val;
  logic [NRP-1:0]  pend_q;
  logic [NRP-1:0]  lk_pend;

  regfile_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP),
    .NWP  (NWP),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .lk_addr  (bus.rd_addr),
    .lk_pend  (lk_pend)
  );

  // Ascending port order means the highest-index writer's assignment lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
          regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      ra[i]       = bus.rd_addr[i*AW +: AW];
      rd_val[i]   = (ra[i] == AW'(ZERO_REG)) ? '0 : regs[ra[i]];
      pend_val[i] = lk_pend[i];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWP; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra[i]) &&
            (ra[i] != AW'(ZERO_REG))) begin
          rd_val[i] = bus.wr_data[j*XLEN +: XLEN];
          // A same-edge reservation keeps the pre-edge pend visible.
          if (!(bus.rsv_en && (bus.rsv_addr == ra[i]))) begin
            pend_val[i] = 1'b0;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRP; i++) begin
        rd_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NRP; i++) begin
        if (bus.rd_en[i]) begin
          rd_q[i]   <= rd_val[i];
          pend_q[i] <= pend_val[i];
        end
      end
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NRP; i++) begin
      bus.rd_data[i*XLEN +: XLEN] = rd_q[i];
    end
    bus.rd_pend = pend_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_en    = '0;
    bus.wr_en    = '0;
    bus.rsv_en   = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_en   = 2'b11;
    bus.rd_addr = {a1, a0};
    step();
    idle();
  endtask

  task automatic wr1(input logic [4:0] a, input logic [63:0] d);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, a};
    bus.wr_data = {64'd0, d};
    step();
    idle();
  endtask

  task automatic rsv(input logic [4:0] a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
    step();
    idle();
  endtask

  function automatic logic [63:0] d0();
    return bus.rd_data[63:0];
  endfunction

  function automatic logic [63:0] d1();
    return bus.rd_data[127:64];
  endfunction

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_addr = '0;
    idle();
    #12;
    check("rst_data0", d0(), 64'd0);
    check("rst_pend", {62'd0, bus.rd_pend}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: empty file after reset
    rd2(5'd5, 5'd31);
    check("t1_data0", d0(), 64'd0);
    check("t1_data1", d1(), 64'd0);
    check("t1_pend", {62'd0, bus.rd_pend}, 64'd0);

    // 2: write then read on both ports; x0 ignores writes
    wr1(5'd3, 64'hDEAD_BEEF_0123_4567);
    rd2(5'd3, 5'd3);
    check("t2_x3_p0", d0(), 64'hDEAD_BEEF_0123_4567);
    check("t2_x3_p1", d1(), 64'hDEAD_BEEF_0123_4567);
    wr1(5'd0, 64'hFFFF);
    rd2(5'd0, 5'd3);
    check("t2_x0", d0(), 64'd0);

    // read disabled: outputs hold while the addressed register changes
    wr1(5'd3, 64'h77);
    bus.rd_addr = {5'd3, 5'd3};
    step();
    check("hold_p0", d0(), 64'd0);
    check("hold_p1", d1(), 64'hDEAD_BEEF_0123_4567);

    // 3: two writers to x7, port 1 wins
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {64'h22, 64'h11};
    step();
    idle();
    rd2(5'd7, 5'd3);
    check("t3_x7", d0(), 64'h22);
    check("t3_x3", d1(), 64'h77);

    // 4: scoreboard
    rsv(5'd9);
    rd2(5'd9, 5'd8);
    check("t4_rsv_pend", {62'd0, bus.rd_pend}, 64'd1);
    wr1(5'd9, 64'h5);
    rd2(5'd9, 5'd9);
    check("t4_wb_pend", {62'd0, bus.rd_pend}, 64'd0);
    check("t4_wb_data", d0(), 64'h5);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd9;
    bus.wr_en    = 2'b10;
    bus.wr_addr  = {5'd9, 5'd0};
    bus.wr_data  = {64'h6, 64'd0};
    step();
    idle();
    rd2(5'd9, 5'd9);
    check("t4_rsv_wr_pend", {62'd0, bus.rd_pend}, 64'd3);
    check("t4_rsv_wr_data", d1(), 64'h6);
    bus.flush    = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd10;
    step();
    idle();
    rd2(5'd9, 5'd10);
    check("t4_flush_pend", {62'd0, bus.rd_pend}, 64'd0);
    rsv(5'd0);
    rd2(5'd0, 5'd0);
    check("t4_rsv_x0", {62'd0, bus.rd_pend}, 64'd0);

    // same-edge reserve and read: pre-edge pend, then set
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd12;
    rd2(5'd12, 5'd12);
    check("rsv_same_edge", {62'd0, bus.rd_pend}, 64'd0);
    rd2(5'd12, 5'd1);
    check("rsv_next", {62'd0, bus.rd_pend}, 64'd1);

    // 5: same-edge write and read
    wr1(5'd4, 64'h1);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd4};
    bus.wr_data = {64'd0, 64'hAB};
    rd2(5'd4, 5'd12);
`ifdef REGFILE_BYPASS_EN
    check("t5_same_edge", d0(), 64'hAB);
`else
    check("t5_same_edge", d0(), 64'h1);
`endif
    rd2(5'd4, 5'd12);
    check("t5_after", d0(), 64'hAB);

    // 6: asynchronous reset between edges
    wr1(5'd2, 64'h9);
    rsv(5'd13);
    rd2(5'd2, 5'd13);
    check("t6_pre_data", d0(), 64'h9);
    check("t6_pre_pend", {62'd0, bus.rd_pend}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_data", d0(), 64'd0);
    check("t6_async_pend", {62'd0, bus.rd_pend}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd2(5'd2, 5'd13);
    check("t6_post_data", d0(), 64'd0);
    check("t6_post_pend", {62'd0, bus.rd_pend}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
